uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter; a responder on the core's data port (addr/we/be/wdata/rdata).
//  The SoC data-address decoder drives sel_i. CPU stores bytes, block serialises them 8N1, LSB first on tx_o.
//  Gives the single-cycle core its first output peripheral next to the dcache.
// PARAMETERS
//  DATA_WIDTH   32      data bus width (rdata/wdata)
//  ADDR_WIDTH   32      address bus width; only addr_i[3:2] decoded
//  FIFO_DEPTH   8       TX FIFO entries, power of 2, >=2 (used only with UART_TX_FIFO_EN)
//  DIV_RESET    434     reset value of BAUDDIV (clk cycles per bit; 50 MHz / 115200)
// PORTS
//  clk      in   1           clock, all logic on rising edge
//  rst      in   1           synchronous, active-high reset
//  sel_i    in   1           access strobe from data-address decoder
//  addr_i   in   ADDR_WIDTH  byte address, word aligned
//  we_i     in   1           0 read access, 1 write access
//  be_i     in   4           byte enable, one bit per lane
//  data_i   in   DATA_WIDTH  write data
//  data_o   out  DATA_WIDTH  read data, registered
//  tx_o     out  1           serial line, idle high
//  irq_o    out  1           level: FIFO empty and shifter idle
// BEHAVIOUR
//  Register map (addr_i[3:2]):
//   0 TXDATA  W: push data_i[7:0] if be_i[0]; R: 0
//   1 STATUS  R: [0] busy (shifter active), [1] full, [2] empty, [3] ovf (sticky), [15:8] fill count
//             W: be_i[0] && data_i[3]==1 clears ovf; other bits ignored
//   2 BAUDDIV RW [15:0], per-lane be_i[1:0]; upper bits read 0; value 0 treated as 1
//   3 unmapped: reads 0, writes ignored
//  Access: valid only when sel_i=1. Write commits on the edge; read data appears on data_o the cycle
//   after the access (1-cycle latency, same as dcache). data_o=0 when the previous cycle had no read.
//  Reset values: data_o=0, tx_o=1, irq_o=1, FIFO empty, ovf=0, BAUDDIV=DIV_RESET, FSM=IDLE.
//  FSM (bit timer cnt counts BAUDDIV-1 down to 0; each bit lasts exactly BAUDDIV clks):
//   IDLE : tx_o=1; if FIFO not empty -> pop into shift reg, load cnt, go START
//   START: tx_o=0; cnt==0 -> DATA, bit_idx=0
//   DATA : tx_o=shift[0]; cnt==0 -> shift right, bit_idx++; after bit 7 -> STOP
//   STOP : tx_o=1; cnt==0 -> IDLE (back-to-back frames: next START directly follows STOP, no extra idle bit)
//  Frame = 10*BAUDDIV clks; first start-bit edge on tx_o 2 clks after TXDATA write into empty idle block.
//  Boundaries:
//   push while full (and no pop same cycle) -> byte dropped, ovf<=1, count unchanged
//   push and pop same cycle while full -> both take effect, count unchanged, no ovf
//   FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH
//   BAUDDIV write mid-frame -> current bit finishes at old value, new value used from next cnt reload
//   rst mid-frame -> tx_o=1 on next edge, frame aborted, FIFO flushed
//   busy=1 from IDLE->START edge until STOP->IDLE edge; irq_o = empty && !busy
// CONFIGURATION
//  UART_TX_FIFO_EN defined  : FIFO of FIFO_DEPTH entries as above.
//  UART_TX_FIFO_EN undefined: single holding register (depth 1); full = holding valid;
//   count field reads 0/1; all overflow and simultaneous push/pop rules apply with depth 1.
// TESTING
//  1 reset: after rst=1 2 clks -> tx_o=1, irq_o=1, STATUS read=0x0000_0004, BAUDDIV read=434
//  2 BAUDDIV=4, write TXDATA 0xA5 -> tx_o: 0,1,0,1,0,0,1,0,1,1 each 4 clks; irq_o 0 until stop ends
//  3 FIFO_EN, BAUDDIV=2, 9 writes 0x00..0x08 in consecutive cycles -> 0x08 dropped... first byte popped at
//    once so 9 accepted, 10th write 0x09 sets ovf; STATUS[3]=1; write STATUS 0x8 -> STATUS[3]=0
//  4 BAUDDIV=3 -> 8 mid-DATA of byte 0x3C -> bits after the current one last 8 clks, byte decoded 0x3C
//  5 rst asserted in DATA of 0xFF with 3 bytes queued -> tx_o=1 next edge, STATUS=0x4, no later frame
//  6 read addr 0xC and write 0xC=0xDEADBEEF -> data_o=0 next cycle, BAUDDIV unchanged

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core data port.
// Registers: TXDATA (push), STATUS (busy/full/empty/ovf/count), BAUDDIV.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// without it a single holding register buffers one byte.
module uart_tx_mmio #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           div_q, div_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_q, tx_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  acc_wr_s;
  logic                  acc_rd_s;
  logic [1:0]            reg_sel_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_set_s;
  logic                  busy_s;
  logic [15:0]           reload_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [7:0]            fifo_count_s;
  logic [7:0]            fifo_count_d_s;
  logic [7:0]            fifo_rdata_s;
  logic                  unused_s;

  assign reg_sel_s = addr_i[3:2];
  assign acc_wr_s  = sel_i & we_i;
  assign acc_rd_s  = sel_i & ~we_i;
  assign push_s    = acc_wr_s & (reg_sel_s == REG_TXDATA) & be_i[0];
  // A push into a full buffer is only lost when nothing leaves it this cycle.
  assign ovf_set_s = push_s & fifo_full_s & ~pop_s;
  assign busy_s    = (state_q != ST_IDLE);
  // Bit timer reload; a divider of 0 behaves like 1.
  assign reload_s  = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

  // Address bits outside [3:2], upper lanes and the depth parameter are not
  // otherwise needed in every build.
  assign unused_s = ^{addr_i[ADDR_WIDTH-1:4], addr_i[1:0], be_i[3:2],
                      data_i[DATA_WIDTH-1:16], (FIFO_DEPTH >= 2)};

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [7:0]       count_q, count_d;
  logic             push_ok_s;

  assign fifo_empty_s   = (count_q == 8'd0);
  assign fifo_full_s    = (count_q == 8'(FIFO_DEPTH));
  assign fifo_rdata_s   = mem_q[rptr_q];
  assign fifo_count_s   = count_q;
  assign fifo_count_d_s = count_d;
  // Full buffer still accepts a push when the shifter pops in the same cycle.
  assign push_ok_s      = push_s & (~fifo_full_s | pop_s);

  // FIFO pointer and fill-count next state; pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= 8'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are qualified by the count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= data_i[7:0];
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       push_ok_s;

  assign fifo_empty_s   = ~hold_vld_q;
  assign fifo_full_s    = hold_vld_q;
  assign fifo_rdata_s   = hold_q;
  assign fifo_count_s   = {7'd0, hold_vld_q};
  assign fifo_count_d_s = {7'd0, hold_vld_d};
  assign push_ok_s      = push_s & (~fifo_full_s | pop_s);

  // Holding register next state: a push wins over a pop and keeps it valid.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (push_ok_s) begin
      hold_d     = data_i[7:0];
      hold_vld_d = 1'b1;
    end else if (pop_s) begin
      hold_vld_d = 1'b0;
    end else begin
      hold_vld_d = hold_vld_q;
    end
  end

  // Holding register state; reset discards any pending byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  // Transmit FSM next state: bit timer, bit index, shifter and buffer pop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          cnt_d   = reload_s;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = reload_s;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload_s;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_rdata_s;
            cnt_d   = reload_s;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level and interrupt next values; both are registered outputs.
  always_comb begin
    tx_d  = 1'b1;
    irq_d = (fifo_count_d_s == 8'd0) && (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Register writes: BAUDDIV per byte lane, sticky overflow flag.
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (acc_wr_s && (reg_sel_s == REG_BAUDDIV)) begin
      if (be_i[0]) begin
        div_d[7:0] = data_i[7:0];
      end else begin
        div_d[7:0] = div_q[7:0];
      end
      if (be_i[1]) begin
        div_d[15:8] = data_i[15:8];
      end else begin
        div_d[15:8] = div_q[15:8];
      end
    end else begin
      div_d = div_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (acc_wr_s && (reg_sel_s == REG_STATUS) && be_i[0] && data_i[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Read mux; data_o is zero after any cycle without a read.
  always_comb begin
    rdata_d = {DATA_WIDTH{1'b0}};
    if (acc_rd_s) begin
      case (reg_sel_s)
        REG_STATUS:  rdata_d[15:0] = {fifo_count_s, 4'd0, ovf_q, fifo_empty_s,
                                      fifo_full_s, busy_s};
        REG_BAUDDIV: rdata_d[15:0] = div_q;
        default:     rdata_d = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rdata_d = {DATA_WIDTH{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= 16'(DIV_RESET);
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
      rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_o = rdata_q;
  assign tx_o   = tx_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: scoreboard queues for serial bytes and
// read data, monitors decode tx_o and data_o independently of the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam int DIV_RST = 434;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        sel_i  = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic        we_i   = 1'b0;
  logic [3:0]  be_i   = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .sel_i  (sel_i),
    .addr_i (addr_i),
    .we_i   (we_i),
    .be_i   (be_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  int          exp_div  = DIV_RST;
  logic [15:0] div_m    = 16'(DIV_RST);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_div();
    return (exp_div == 0) ? 1 : exp_div;
  endfunction

  // All bus tasks are entered right after a falling edge and return on the next one.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; be_i = b;
    @(negedge clk);
    sel_i = 1'b0; we_i = 1'b0; be_i = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    sel_i = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_write(32'h0, {24'd0, b}, 4'b0001);
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(32'h8, {16'd0, d}, 4'b0011);
    div_m   = d;
    exp_div = int'(d);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (irq_o !== 1'b1 && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("irq_idle_wait", {31'd0, irq_o}, 32'd1);
    repeat (eff_div() + 3) @(negedge clk);
  endtask

  // Read-data monitor: data_o after a read must match the queued value, else zero.
  initial begin : rd_mon
    logic was_rd;
    forever begin
      @(posedge clk);
      was_rd = sel_i && !we_i && !rst;
      @(negedge clk);
      if (was_rd) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h required no read", data_o);
        end else begin
          check("rd_data", data_o, rd_q.pop_front());
        end
      end else begin
        check("rd_idle_zero", data_o, 32'd0);
      end
    end
  end

  // Serial monitor: decodes 8N1 frames, each bit held for the expected divider.
  initial begin : tx_mon
    int         st;
    int         bit_n;
    int         cnt;
    int         len;
    logic       val;
    logic [7:0] byte_v;
    st = 0; bit_n = 0; cnt = 0; len = 1; val = 1'b1; byte_v = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st = 0;
      end else begin
        if (st == 0 && tx_o === 1'b0) begin
          st = 1; bit_n = 0; cnt = 0;
        end
        if (st == 1) begin
          if (cnt == 0) begin
            len = eff_div();
            val = tx_o;
            if (bit_n >= 1 && bit_n <= 8) byte_v[bit_n-1] = tx_o;
          end else begin
            check("tx_bit_stable", {31'd0, tx_o}, {31'd0, val});
          end
          cnt++;
          if (cnt == len) begin
            cnt = 0;
            if (bit_n == 9) begin
              check("tx_stop_bit", {31'd0, val}, 32'd1);
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected_frame: got 0x%02h required none", byte_v);
              end else begin
                check("tx_byte", {24'd0, byte_v}, {24'd0, exp_q.pop_front()});
              end
              st = 0;
            end else begin
              bit_n++;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0]  seq;
    logic [15:0] rv;
    logic [1:0]  rb;
    int          d;
    int          n;
    int          extra;
    int          lows;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    check("reset_irq", {31'd0, irq_o}, 32'd1);
    rst = 1'b0;
    bus_read(32'h4, 32'h0000_0004);
    bus_read(32'h8, 32'(DIV_RST));

    // Unmapped slot reads zero and ignores writes
    bus_read(32'hC, 32'd0);
    bus_write(32'hC, 32'hDEAD_BEEF, 4'hF);
    bus_read(32'h8, 32'(DIV_RST));

    // Exact waveform of 0xA5 at divider 4
    set_div(16'd4);
    seq = 10'b11_0100_1010;
    push_byte(8'hA5, 1'b1);
    check("irq_after_write", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    check("tx_before_start", {31'd0, tx_o}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("tx_a5_wave", {31'd0, tx_o}, {31'd0, seq[k/4]});
      if (k <= 38) check("irq_during_frame", {31'd0, irq_o}, 32'd0);
    end
    @(negedge clk);
    check("irq_after_frame", {31'd0, irq_o}, 32'd1);
    check("tx_idle_after", {31'd0, tx_o}, 32'd1);
    bus_read(32'h4, 32'h0000_0004);

    // Divider change in the middle of data bit 2 of 0x3C
    set_div(16'd3);
    push_byte(8'h3C, 1'b1);
    repeat (11) @(negedge clk);
    bus_write(32'h8, 32'd8, 4'b0011);
    div_m   = 16'd8;
    exp_div = 8;
    wait_idle(5000);
    bus_read(32'h8, 32'd8);

    // Overflow at capacity (buffer plus shifter) and clearing ovf
    set_div(16'd2);
    for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(i), i <= DEPTH);
    bus_read(32'h4, (32'(DEPTH) << 8) | 32'h0000_000B);
    bus_write(32'h4, 32'h0000_0008, 4'b0001);
    bus_read(32'h4, (32'(DEPTH) << 8) | 32'h0000_0003);
    wait_idle(20000);
    bus_read(32'h4, 32'h0000_0004);

    // Randomized bursts, dividers (including 0) and lane-masked divider writes
    for (int it = 0; it < 8; it++) begin
      rv = 16'($urandom);
      rb = 2'($urandom_range(0, 3));
      bus_write(32'h8, {16'hFFFF, rv}, {2'b00, rb});
      if (rb[0]) div_m[7:0]  = rv[7:0];
      if (rb[1]) div_m[15:8] = rv[15:8];
      bus_read(32'h8, {16'd0, div_m});
      d = $urandom_range(0, 5);
      set_div(16'(d));
      extra = ((d >= 2) && (it % 2 == 1)) ? $urandom_range(1, 2) : 0;
      n = (extra > 0) ? DEPTH + 1 : $urandom_range(1, DEPTH + 1);
      for (int j = 0; j < n + extra; j++) push_byte(8'($urandom), j < n);
      wait_idle(20000);
      bus_read(32'h4, (extra > 0) ? 32'h0000_000C : 32'h0000_0004);
      if (extra > 0) begin
        bus_write(32'h4, 32'h0000_0008, 4'b0001);
        bus_read(32'h4, 32'h0000_0004);
      end
    end

    // Reset in the middle of a data bit with bytes still queued
    set_div(16'd4);
    n = (DEPTH >= 3) ? 4 : DEPTH + 1;
    for (int j = 0; j < n; j++) push_byte(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("tx_after_rst", {31'd0, tx_o}, 32'd1);
    check("irq_after_rst", {31'd0, irq_o}, 32'd1);
    @(negedge clk);
    rst     = 1'b0;
    exp_div = DIV_RST;
    div_m   = 16'(DIV_RST);
    bus_read(32'h4, 32'h0000_0004);
    bus_read(32'h8, 32'(DIV_RST));
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    check("tx_quiet_after_rst", 32'(lows), 32'd0);

    check("tx_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
